// File: rtl/mem_arbiter_if.sv
// Bundle of the three memory ports around mem_arbiter: core fetch port, core data port, unified downstream port.
// The slave modport is the arbiter's view; master is the view of everything around it (core and memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_rd_addr;
  logic              imem_rd_enable;
  logic [DATA_W-1:0] imem_rd_data;
  logic              imem_rd_ready;

  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_r_enable;
  logic              dmem_w_enable;
  logic [1:0]        dmem_w_size;
  logic [DATA_W-1:0] dmem_w_data;
  logic [DATA_W-1:0] dmem_r_data;
  logic              dmem_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_r_enable;
  logic              mem_w_enable;
  logic [1:0]        mem_w_size;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;
  logic              mem_ready;

  modport slave (
    input  imem_rd_addr, imem_rd_enable,
    input  dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_size, dmem_w_data,
    input  mem_r_data, mem_ready,
    output imem_rd_data, imem_rd_ready,
    output dmem_r_data, dmem_ready,
    output mem_addr, mem_r_enable, mem_w_enable, mem_w_size, mem_w_data
  );

  modport master (
    output imem_rd_addr, imem_rd_enable,
    output dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_size, dmem_w_data,
    output mem_r_data, mem_ready,
    input  imem_rd_data, imem_rd_ready,
    input  dmem_r_data, dmem_ready,
    input  mem_addr, mem_r_enable, mem_w_enable, mem_w_size, mem_w_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising the core's fetch and data ports onto one single-port memory.
// One access in flight at a time: IDLE picks a port, ISSUE waits on mem_ready, DONE pulses that port's ready.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic grant_d;
  logic grant_next;
  logic last_d;
  logic load;
  logic complete;
  logic i_req;
  logic d_req;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_r_enable_q;
  logic              mem_w_enable_q;
  logic [1:0]        mem_w_size_q;
  logic [DATA_W-1:0] mem_w_data_q;
  logic [DATA_W-1:0] imem_rd_data_q;
  logic [DATA_W-1:0] dmem_r_data_q;
  logic [1:0]        d_size;

  assign i_req  = bus.imem_rd_enable;
  assign d_req  = bus.dmem_r_enable | bus.dmem_w_enable;
  assign d_size = (bus.dmem_w_size == 2'b11) ? 2'b10 : bus.dmem_w_size;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant_d <= 1'b0;
    end else begin
      state   <= state_next;
      grant_d <= grant_next;
    end
  end

  // On a tie the port that was not served last wins; last_d=0 after reset so data wins first.
  always_comb begin
    state_next = state;
    grant_next = grant_d;
    load       = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_next = d_req && (!i_req || !last_d);
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A data request with both enables set is a store, so the read enable is masked by the write enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q     <= '0;
      mem_r_enable_q <= 1'b0;
      mem_w_enable_q <= 1'b0;
      mem_w_size_q   <= 2'b00;
      mem_w_data_q   <= '0;
      imem_rd_data_q <= '0;
      dmem_r_data_q  <= '0;
      last_d         <= 1'b0;
    end else if (load) begin
      if (grant_next) begin
        mem_addr_q     <= bus.dmem_addr;
        mem_r_enable_q <= bus.dmem_r_enable & ~bus.dmem_w_enable;
        mem_w_enable_q <= bus.dmem_w_enable;
        mem_w_size_q   <= d_size;
        mem_w_data_q   <= bus.dmem_w_data;
      end else begin
        mem_addr_q     <= bus.imem_rd_addr;
        mem_r_enable_q <= 1'b1;
        mem_w_enable_q <= 1'b0;
        mem_w_size_q   <= 2'b10;
        mem_w_data_q   <= '0;
      end
    end else if (complete) begin
      mem_r_enable_q <= 1'b0;
      mem_w_enable_q <= 1'b0;
      last_d         <= grant_d;
      if (mem_r_enable_q) begin
        if (grant_d) begin
          dmem_r_data_q <= bus.mem_r_data;
        end else begin
          imem_rd_data_q <= bus.mem_r_data;
        end
      end
    end
  end

  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_r_enable  = mem_r_enable_q;
  assign bus.mem_w_enable  = mem_w_enable_q;
  assign bus.mem_w_size    = mem_w_size_q;
  assign bus.mem_w_data    = mem_w_data_q;
  assign bus.imem_rd_data  = imem_rd_data_q;
  assign bus.dmem_r_data   = dmem_r_data_q;
  assign bus.imem_rd_ready = (state == DONE) && !grant_d;
  assign bus.dmem_ready    = (state == DONE) && grant_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory on the downstream port.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   wait_cycles;
  int   busy_cnt;
  int   i_pulses;
  int   d_pulses;

  logic [31:0] mem [0:255];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory answers after wait_cycles ISSUE cycles with ready held 0, then one cycle of ready.
  initial begin
    int lane;
    bus.mem_ready  = 1'b0;
    bus.mem_r_data = '0;
    busy_cnt       = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_r_enable || bus.mem_w_enable) begin
        busy_cnt++;
        if (busy_cnt > wait_cycles) begin
          bus.mem_ready = 1'b1;
          lane = int'(bus.mem_addr[1:0]);
          if (bus.mem_w_enable) begin
            case (bus.mem_w_size)
              2'b00:   mem[bus.mem_addr[9:2]][8*lane +: 8]          = bus.mem_w_data[7:0];
              2'b01:   mem[bus.mem_addr[9:2]][16*(lane/2) +: 16]    = bus.mem_w_data[15:0];
              default: mem[bus.mem_addr[9:2]]                       = bus.mem_w_data;
            endcase
          end else begin
            bus.mem_r_data = mem[bus.mem_addr[9:2]];
          end
        end else begin
          bus.mem_ready = 1'b0;
        end
      end else begin
        busy_cnt      = 0;
        bus.mem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.imem_rd_ready) i_pulses++;
    if (bus.dmem_ready) d_pulses++;
    if (reset) begin
      checks++;
      assert (!(bus.imem_rd_ready && bus.dmem_ready)) else begin
        failures++;
        $error("FAIL dual_ready observed=11 expected=not both");
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issues one request from the chosen port at the current falling edge and waits for its ready pulse.
  task automatic apply_stimulus(input string tag, input bit is_d, input logic [31:0] addr,
                                input logic rd, input logic wr, input logic [1:0] size,
                                input logic [31:0] wdata, output int cycles, output logic [31:0] rdata,
                                output logic issue_r, output logic issue_w, output logic [1:0] issue_size);
    bit done;
    if (is_d) begin
      bus.dmem_addr     = addr;
      bus.dmem_r_enable = rd;
      bus.dmem_w_enable = wr;
      bus.dmem_w_size   = size;
      bus.dmem_w_data   = wdata;
    end else begin
      bus.imem_rd_addr   = addr;
      bus.imem_rd_enable = 1'b1;
    end
    cycles = 1;
    done   = 1'b0;
    @(negedge clk);
    cycles++;
    issue_r    = bus.mem_r_enable;
    issue_w    = bus.mem_w_enable;
    issue_size = bus.mem_w_size;
    while (!done && cycles < 40) begin
      if (is_d ? bus.dmem_ready : bus.imem_rd_ready) done = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    rdata = is_d ? bus.dmem_r_data : bus.imem_rd_data;
    bus.imem_rd_enable = 1'b0;
    bus.dmem_r_enable  = 1'b0;
    bus.dmem_w_enable  = 1'b0;
    @(negedge clk);
    check_output({tag, "_pulse_end"}, {31'b0, is_d ? bus.dmem_ready : bus.imem_rd_ready}, 32'h0);
  endtask

  initial begin
    int          cyc;
    int          n;
    int          stable;
    int          d_before;
    int          i_before;
    logic [31:0] rdata;
    logic        ir;
    logic        iw;
    logic [1:0]  isz;
    logic [31:0] grant_seen [4];
    logic [31:0] addr_seen [4];

    checks = 0; failures = 0; wait_cycles = 0; i_pulses = 0; d_pulses = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'h00500093;
    mem[8'h08] = 32'h11111111;
    mem[8'h09] = 32'h22222222;
    mem[8'h80] = 32'hAAAA0001;
    reset = 1'b0;
    bus.imem_rd_addr = '0; bus.imem_rd_enable = 1'b0;
    bus.dmem_addr = '0; bus.dmem_r_enable = 1'b0; bus.dmem_w_enable = 1'b0;
    bus.dmem_w_size = 2'b00; bus.dmem_w_data = '0;

    repeat (2) @(negedge clk);
    check_output("rst_mem_r_enable", {31'b0, bus.mem_r_enable}, 32'h0);
    check_output("rst_mem_w_enable", {31'b0, bus.mem_w_enable}, 32'h0);
    check_output("rst_mem_addr", bus.mem_addr, 32'h0);
    check_output("rst_ready", {30'b0, bus.imem_rd_ready, bus.dmem_ready}, 32'h0);
    check_output("rst_rdata", bus.imem_rd_data | bus.dmem_r_data, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // single fetch
    d_before = d_pulses;
    apply_stimulus("fetch", 1'b0, 32'h10, 1'b1, 1'b0, 2'b10, 32'h0, cyc, rdata, ir, iw, isz);
    check_output("fetch_latency", cyc, 32'd3);
    check_output("fetch_data", rdata, 32'h00500093);
    check_output("fetch_issue_r", {31'b0, ir}, 32'h1);
    check_output("fetch_no_dready", d_pulses - d_before, 32'h0);

    // store then load
    apply_stimulus("store", 1'b1, 32'h100, 1'b0, 1'b1, 2'b10, 32'hDEADBEEF, cyc, rdata, ir, iw, isz);
    check_output("store_w_enable", {31'b0, iw}, 32'h1);
    check_output("store_r_enable", {31'b0, ir}, 32'h0);
    check_output("store_w_size", {30'b0, isz}, 32'h2);
    check_output("store_keeps_rdata", rdata, 32'h0);
    apply_stimulus("load", 1'b1, 32'h100, 1'b1, 1'b0, 2'b10, 32'h0, cyc, rdata, ir, iw, isz);
    check_output("load_latency", cyc, 32'd3);
    check_output("load_data", rdata, 32'hDEADBEEF);

    // both ports held together after reset: D, I, D, I
    apply_reset();
    for (int i = 0; i < 4; i++) begin grant_seen[i] = 32'hFFFF_FFFF; addr_seen[i] = 32'hFFFF_FFFF; end
    bus.dmem_addr = 32'h200; bus.dmem_r_enable = 1'b1;
    bus.imem_rd_addr = 32'h20; bus.imem_rd_enable = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (bus.dmem_ready || bus.imem_rd_ready) begin
        grant_seen[n] = {31'b0, bus.dmem_ready};
        addr_seen[n]  = bus.mem_addr;
        n++;
        if (n == 4) begin bus.dmem_r_enable = 1'b0; bus.imem_rd_enable = 1'b0; end
      end
    end
    check_output("rr_grant0", grant_seen[0], 32'h1);
    check_output("rr_grant1", grant_seen[1], 32'h0);
    check_output("rr_grant2", grant_seen[2], 32'h1);
    check_output("rr_grant3", grant_seen[3], 32'h0);
    check_output("rr_addr0", addr_seen[0], 32'h200);
    check_output("rr_addr1", addr_seen[1], 32'h20);
    check_output("rr_addr2", addr_seen[2], 32'h200);
    check_output("rr_addr3", addr_seen[3], 32'h20);
    check_output("rr_ddata", bus.dmem_r_data, 32'hAAAA0001);
    check_output("rr_idata", bus.imem_rd_data, 32'h11111111);
    @(negedge clk);

    // wait states: five ISSUE cycles
    wait_cycles = 4;
    bus.imem_rd_addr = 32'h24; bus.imem_rd_enable = 1'b1;
    stable = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.mem_addr == 32'h24 && bus.mem_r_enable && !bus.imem_rd_ready) stable++;
    end
    check_output("wait_stable", stable, 32'd5);
    @(negedge clk);
    check_output("wait_ready_cycle7", {31'b0, bus.imem_rd_ready}, 32'h1);
    check_output("wait_data", bus.imem_rd_data, 32'h22222222);
    bus.imem_rd_enable = 1'b0;
    @(negedge clk);
    check_output("wait_pulse_end", {31'b0, bus.imem_rd_ready}, 32'h0);

    // reset during a pending fetch
    wait_cycles = 10;
    bus.imem_rd_addr = 32'h10; bus.imem_rd_enable = 1'b1;
    repeat (2) @(negedge clk);
    check_output("midrst_pending", {31'b0, bus.mem_r_enable}, 32'h1);
    i_before = i_pulses;
    reset = 1'b0;
    #1;
    check_output("midrst_r_enable", {31'b0, bus.mem_r_enable}, 32'h0);
    check_output("midrst_addr", bus.mem_addr, 32'h0);
    check_output("midrst_rdata", bus.imem_rd_data | bus.dmem_r_data, 32'h0);
    bus.imem_rd_enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("midrst_no_iready", i_pulses - i_before, 32'h0);
    wait_cycles = 0;
    reset = 1'b1;
    @(negedge clk);
    apply_stimulus("refetch", 1'b0, 32'h10, 1'b1, 1'b0, 2'b10, 32'h0, cyc, rdata, ir, iw, isz);
    check_output("refetch_latency", cyc, 32'd3);
    check_output("refetch_data", rdata, 32'h00500093);

    // both data enables: treated as a store
    apply_stimulus("preload", 1'b1, 32'h200, 1'b1, 1'b0, 2'b10, 32'h0, cyc, rdata, ir, iw, isz);
    check_output("preload_data", rdata, 32'hAAAA0001);
    d_before = d_pulses;
    apply_stimulus("bothen", 1'b1, 32'h300, 1'b1, 1'b1, 2'b10, 32'h12345678, cyc, rdata, ir, iw, isz);
    check_output("bothen_w_enable", {31'b0, iw}, 32'h1);
    check_output("bothen_r_enable", {31'b0, ir}, 32'h0);
    check_output("bothen_rdata_kept", rdata, 32'hAAAA0001);
    check_output("bothen_one_pulse", d_pulses - d_before, 32'h1);
    apply_stimulus("readback", 1'b1, 32'h300, 1'b1, 1'b0, 2'b10, 32'h0, cyc, rdata, ir, iw, isz);
    check_output("readback_data", rdata, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder that serves both memory ports of `minuteCore` and drives one unified single-port memory. The instruction-fetch port (`imem_rd_*`) and the data port (`dmem_*`) each see a normal memory responder. Requests are serialised onto one downstream port using the same enable/ready protocol. Simultaneous requests are arbitrated round-robin, so neither fetch nor load/store can starve.

## Interface
- `ADDR_W`, default 32: address width (`ADDR_SIZE`+1).
- `DATA_W`, default 32: data width (`INSTR_SIZE`+1).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `imem_rd_addr`  in  ADDR_W  fetch address.
- `imem_rd_enable`  in  1  fetch request; held high by the core until `imem_rd_ready`.
- `imem_rd_data`  out  DATA_W  fetched instruction; valid while `imem_rd_ready` is high.
- `imem_rd_ready`  out  1  one-cycle fetch completion pulse.
- `dmem_addr`  in  ADDR_W  data address.
- `dmem_r_enable`, `dmem_w_enable`  in  1 each  load/store request; held until `dmem_ready`.
- `dmem_w_size`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `dmem_w_data`  in  DATA_W  store data.
- `dmem_r_data`  out  DATA_W  load data; valid while `dmem_ready` is high.
- `dmem_ready`  out  1  one-cycle data completion pulse.
- `mem_addr`  out  ADDR_W  downstream address (registered).
- `mem_r_enable`, `mem_w_enable`  out  1 each  downstream request (registered).
- `mem_w_size`  out  2  downstream store size.
- `mem_w_data`  out  DATA_W  downstream store data.
- `mem_r_data`  in  DATA_W  downstream read data; valid with `mem_ready`.
- `mem_ready`  in  1  downstream completion; sampled only in ISSUE.

## Operation
- FSM states are IDLE, ISSUE and DONE. A 1-bit `grant_d` register records whether ISSUE currently serves the data port (1) or fetch (0). A 1-bit `last_d` register records the port served most recently; it resets to 0.
- In IDLE, the block samples the request lines:
  - Neither port requesting: stay in IDLE.
  - Only one port requesting: grant that port.
  - Both requesting: grant the port not equal to `last_d`. After reset, data wins the first tie.
- On a grant, the block latches addr, r/w enables, size and write data into the `mem_*` registers, sets `grant_d`, and goes to ISSUE.
- In ISSUE, the block holds all `mem_*` outputs stable. When `mem_ready`=1:
  - It drops `mem_r_enable`/`mem_w_enable`.
  - For a read, it latches `mem_r_data` into the selected port's data register.
  - It updates `last_d` to `grant_d` and goes to DONE.
- In DONE, the block asserts exactly one of `imem_rd_ready`/`dmem_ready` for that single cycle, then returns to IDLE.
- A data write completion leaves `dmem_r_data` unchanged. Each port's data output holds its last read value between reads.
- If both `dmem_r_enable` and `dmem_w_enable` are high, the request is treated as a write: `mem_r_enable`=0 and `mem_w_enable`=1.
- A requester that drops its enable during ISSUE does not abort the access. The downstream access completes and the ready pulse is still issued.
- Requests are never re-sampled outside IDLE. Changes on request inputs during ISSUE/DONE have no effect.

## Timing
- Reset (asynchronous, `reset`=0):
  - State goes to IDLE; `last_d`=0.
  - All outputs are 0: `mem_*`, `imem_rd_data`, `dmem_r_data`, and both ready signals.
- Deasserting `reset` takes effect at the next rising edge.
- If reset is asserted mid-transaction, the access is abandoned: no ready pulse, `mem_*` enables go low immediately. The downstream memory must tolerate an enable withdrawn without completion.
- Latency: a request present in IDLE at edge 0 gives `mem_*` enable high after edge 0. If `mem_ready` is high in cycle k of ISSUE (k≥1), the upstream ready is high in the cycle after that edge.
- Total latency is N+2 cycles from the request edge to the ready cycle, where N is the number of ISSUE cycles.
- Throughput is at most one transaction per N+2 cycles.
- No ready pulse is ever high on both ports in the same cycle.
- In the cycle after DONE (IDLE), a request that is still asserted is treated as a new request. The core must therefore update or drop its enable on the edge that ends the ready cycle.

## Test plan
- Single fetch: `imem_rd_addr`=0x10, with a memory returning 0x00500093 and `mem_ready` in the first ISSUE cycle. Required: `imem_rd_ready` pulses one cycle, 3 cycles after the request edge, with `imem_rd_data`=0x00500093; `dmem_ready` stays 0.
- Store then load: write 0xDEADBEEF at 0x100 with size 10, then read 0x100. Required: `mem_w_enable`=1 with `mem_w_size`=10 during the write. The read returns `dmem_r_data`=0xDEADBEEF. `dmem_r_data` is unchanged by the write completion.
- Simultaneous requests, four back-to-back transactions from both ports after reset. Required grant order is D, I, D, I. `mem_addr` alternates between the data and fetch addresses.
- Wait states: memory holds `mem_ready`=0 for 4 cycles. Required: `mem_addr`/`mem_r_enable` stay stable for all 5 ISSUE cycles; ready arrives 7 cycles after the request.
- Reset mid-ISSUE: assert `reset`=0 during a pending fetch. Required: `mem_r_enable`=0 immediately, no `imem_rd_ready` pulse, and all outputs 0. After release, a new fetch completes normally.
- Both enables: `dmem_r_enable`=`dmem_w_enable`=1. Required: `mem_w_enable`=1 and `mem_r_enable`=0, one `dmem_ready` pulse, `dmem_r_data` unchanged.
